kyber_reject_sampler_core: RTL and testbench

//  Multi-lane rejection sampler for the Kyber sampling path (q = 3329).
//  - Each cycle, tests LANES 12-bit candidates in parallel.
//  - Per-lane mode: uniform rejection against q, or threshold (Bernoulli) test.
//  - Accepted candidates are packed toward lane 0 and emitted on a valid-qualified sample bus.
//  - Sits between the XOF/PRNG unpacker and the polynomial coefficient buffer.

---
 rtl/kyber_reject_sampler_core_if.sv | 33 +++
 rtl/kyber_reject_sampler_core.sv | 101 ++++++++++
 tb/tb_kyber_reject_sampler_core.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/kyber_reject_sampler_core_if.sv
// Sample-path bus for kyber_reject_sampler_core.
// master drives candidate beats; slave is the sampler core.
interface kyber_reject_sampler_core_if #(
  parameter int LANES     = 4,
  parameter int CAND_BITS = 12
);
  localparam int W = LANES * CAND_BITS;

  logic             random_valid;
  logic [127:0]     random_in;
  logic [15:0]      q;
  logic [W-1:0]     cand_bus;
  logic [W-1:0]     urnd_bus;
  logic [W-1:0]     threshold_bus;
  logic [LANES-1:0] mode_select;
  logic [LANES-1:0] acc_bus;
  logic [W-1:0]     sample_tdata;
  logic             sample_tvalid;

  modport master (
    output random_valid, random_in, q,
    output cand_bus, urnd_bus, threshold_bus,
    output mode_select,
    input  acc_bus, sample_tdata, sample_tvalid
  );

  modport slave (
    input  random_valid, random_in, q,
    input  cand_bus, urnd_bus, threshold_bus,
    input  mode_select,
    output acc_bus, sample_tdata, sample_tvalid
  );
endinterface

// File: rtl/kyber_reject_sampler_core.sv
// Multi-lane Kyber rejection sampler with lane-0-first compaction.
// Optional REJECT_RAND_CAND_EN: take candidates from random_in.
module kyber_reject_sampler_core #(
  parameter int LANES      = 4,
  parameter int CAND_BITS  = 12,
  parameter bit CONST_TIME = 1'b1
) (
  input logic clk,
  input logic rst,
  kyber_reject_sampler_core_if.slave sif
);
  localparam int W  = LANES * CAND_BITS;
  localparam int CW = $clog2(LANES) + 1;

  logic [CAND_BITS-1:0] w_cand [LANES];
  logic [LANES-1:0]     w_acc;
  logic [W-1:0]         w_tdata;
  logic                 w_tvalid;
  logic [CW-1:0]        w_rank;

  logic [LANES-1:0]     r_acc;
  logic [W-1:0]         r_tdata;
  logic                 r_tvalid;

`ifdef REJECT_RAND_CAND_EN
  if (W > 128) begin : g_width_chk
    $error("LANES*CAND_BITS must not exceed 128");
  end

  wire w_unused_cand = ^sif.cand_bus;

  // Candidates are sliced straight out of the entropy word.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      w_cand[i] = sif.random_in[i*CAND_BITS +: CAND_BITS];
    end
  end
`else
  wire w_unused_rand = ^sif.random_in;

  // Candidates come from the unpacked candidate bus.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      w_cand[i] = sif.cand_bus[i*CAND_BITS +: CAND_BITS];
    end
  end
`endif

  // Per-lane accept test, gated by beat valid.
  always_comb begin
    w_acc = '0;
    for (int i = 0; i < LANES; i++) begin
      if (sif.mode_select[i]) begin
        w_acc[i] = sif.urnd_bus[i*CAND_BITS +: CAND_BITS]
                 < sif.threshold_bus[i*CAND_BITS +: CAND_BITS];
      end else begin
        w_acc[i] = {{(16-CAND_BITS){1'b0}}, w_cand[i]} < sif.q;
      end
    end
    if (!sif.random_valid) begin
      w_acc = '0;
    end
  end

  // Fixed AND-OR compaction: lane i lands in slot rank(i).
  always_comb begin
    w_tdata = '0;
    w_rank  = '0;
    for (int i = 0; i < LANES; i++) begin
      for (int j = 0; j < LANES; j++) begin
        w_tdata[j*CAND_BITS +: CAND_BITS] =
          w_tdata[j*CAND_BITS +: CAND_BITS]
          | (w_cand[i]
             & {CAND_BITS{w_acc[i] & (w_rank == CW'(j))}});
      end
      w_rank = w_rank + CW'(w_acc[i]);
    end
  end

  // Valid policy: every beat, or only beats with an accept.
  always_comb begin
    w_tvalid = CONST_TIME ? sif.random_valid : |w_acc;
  end

  // Output registers; no combinational input-to-output path.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc    <= '0;
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
    end else begin
      r_acc    <= w_acc;
      r_tdata  <= w_tdata;
      r_tvalid <= w_tvalid;
    end
  end

  assign sif.acc_bus       = r_acc;
  assign sif.sample_tdata  = r_tdata;
  assign sif.sample_tvalid = r_tvalid;
endmodule

// File: tb/tb_kyber_reject_sampler_core.sv
// Directed table-driven bench for kyber_reject_sampler_core.
// Default build: CONST_TIME=1, candidates from cand_bus.
module tb_kyber_reject_sampler_core;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  kyber_reject_sampler_core_if #(.LANES(4), .CAND_BITS(12)) bus ();

  kyber_reject_sampler_core #(
    .LANES(4), .CAND_BITS(12), .CONST_TIME(1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .sif (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [15:0] q;
    logic [3:0]  mode;
    logic [47:0] cand;
    logic [47:0] urnd;
    logic [47:0] thr;
    logic [3:0]  e_acc;
    logic [47:0] e_tdata;
    logic        e_tvalid;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] acc,
                           input logic [47:0] td, input logic tv);
    check({tag, ".acc"}, 64'(bus.acc_bus), 64'(acc));
    check({tag, ".tdata"}, 64'(bus.sample_tdata), 64'(td));
    check({tag, ".tvalid"}, 64'(bus.sample_tvalid), 64'(tv));
  endtask

  task automatic drive(input vec_t v);
    bus.random_valid  = v.valid;
    bus.q             = v.q;
    bus.mode_select   = v.mode;
    bus.cand_bus      = v.cand;
    bus.urnd_bus      = v.urnd;
    bus.threshold_bus = v.thr;
  endtask

  task automatic drive_random();
    bus.random_valid  = 1'b1;
    bus.random_in     = {$urandom, $urandom, $urandom, $urandom};
    bus.q             = 16'hFFFF;
    bus.mode_select   = 4'($urandom);
    bus.cand_bus      = {16'($urandom), $urandom};
    bus.urnd_bus      = {16'($urandom), $urandom};
    bus.threshold_bus = {16'($urandom), $urandom};
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // uniform q=3329: lanes 000,D01,D00,FFF
    vecs[0] = '{1'b1, 16'd3329, 4'b0000, 48'hFFFD00D01000, 48'h0, 48'h0,
                4'b0101, 48'h000000D00000, 1'b1};
    // threshold: urnd 5s, thr 6,5,0,FFF
    vecs[1] = '{1'b1, 16'd3329, 4'b1111, 48'hABC123456789,
                48'h005005005005, 48'hFFF000005006,
                4'b1001, 48'h000000ABC789, 1'b1};
    // all reject, q=0
    vecs[2] = '{1'b1, 16'd0, 4'b0000, 48'h001002003004, 48'h0, 48'h0,
                4'b0000, 48'h0, 1'b1};
    // invalid beat carrying accepting data
    vecs[3] = '{1'b0, 16'd3329, 4'b0000, 48'hFFFD00D01000, 48'h0, 48'h0,
                4'b0000, 48'h0, 1'b0};
    // mixed modes: lanes 0,1,3 accept
    vecs[4] = '{1'b1, 16'd3329, 4'b0110, 48'hD00200E00100,
                48'h000009001000, 48'h000003002000,
                4'b1011, 48'h000D00E00100, 1'b1};
    // q=FFFF accepts everything
    vecs[5] = '{1'b1, 16'hFFFF, 4'b0000, 48'hFFF123000ABC, 48'h0, 48'h0,
                4'b1111, 48'hFFF123000ABC, 1'b1};
    // q=1: only zero candidates pass
    vecs[6] = '{1'b1, 16'd1, 4'b0000, 48'h005000001000, 48'h0, 48'h0,
                4'b0101, 48'h0, 1'b1};
    // only lane 3 accepts, moves to slot 0
    vecs[7] = '{1'b1, 16'd3329, 4'b0000, 48'h123FFFFFFFFF, 48'h0, 48'h0,
                4'b1000, 48'h000000000123, 1'b1};

    // Reset held 3 cycles with random valid inputs
    rst = 1'b1;
    drive_random();
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check_out($sformatf("reset%0d", c), 4'b0, 48'h0, 1'b0);
      drive_random();
    end
    @(negedge clk);
    rst = 1'b0;
    bus.random_valid = 1'b0;
    @(posedge clk);
    #1;
    check_out("post_reset_idle", 4'b0, 48'h0, 1'b0);

    // Back-to-back table beats, one per cycle
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      drive(vecs[k]);
      @(posedge clk);
      #1;
      check_out($sformatf("vec%0d", k), vecs[k].e_acc,
                vecs[k].e_tdata, vecs[k].e_tvalid);
    end

    // Beat in flight when reset hits is dropped
    @(negedge clk);
    drive(vecs[0]);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_out("drop_inflight", 4'b0, 48'h0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    drive(vecs[7]);
    @(posedge clk);
    #1;
    check_out("first_after_reset", 4'b1000, 48'h000000000123, 1'b1);

    // Valid drops after an accepting beat: no stale output
    @(negedge clk);
    bus.random_valid = 1'b0;
    @(posedge clk);
    #1;
    check_out("valid_drop", 4'b0, 48'h0, 1'b0);

`ifdef REJECT_RAND_CAND_EN
    @(negedge clk);
    bus.random_valid  = 1'b1;
    bus.q             = 16'd3329;
    bus.mode_select   = 4'b0000;
    bus.cand_bus      = 48'hFFFFFFFFFFFF;
    bus.random_in     = {80'h0, 48'hFFFFFFFFF010};
    @(posedge clk);
    #1;
    check_out("rand_cand", 4'b0001, 48'h000000000010, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
